// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types, default width and seven-segment decode for the divider
package divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/divider_if.sv
// rtl/divider_if.sv - board-side operand/result bundle; hex images exist only with DIVIDER_HEX_EN
interface divider_if #(parameter int WIDTH = 8);
    logic             LoadDivisor;
    logic             Run;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Done;
    logic             DivByZero;
`ifdef DIVIDER_HEX_EN
    logic [6:0]       QhexU;
    logic [6:0]       QhexL;
    logic [6:0]       RhexU;
    logic [6:0]       RhexL;
`endif

    modport master (
        output LoadDivisor, Run, SW,
        input  Quotient, Remainder, Done, DivByZero
`ifdef DIVIDER_HEX_EN
        , input QhexU, QhexL, RhexU, RhexL
`endif
    );

    modport slave (
        input  LoadDivisor, Run, SW,
        output Quotient, Remainder, Done, DivByZero
`ifdef DIVIDER_HEX_EN
        , output QhexU, QhexL, RhexU, RhexL
`endif
    );
endinterface

// File: rtl/divider_control.sv
// rtl/divider_control.sv - sequencing FSM and bit counter for the restoring divider
module divider_control
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    input  logic run_n,
    input  logic load_div_n,
    output logic load_strobe,
    output logic div_load,
    output logic step_en,
    output logic done_strobe
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_strobe = 1'b0;
        div_load    = 1'b0;
        step_en     = 1'b0;
        done_strobe = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Run wins over LoadDivisor so a start never races a divisor change.
                if (!run_n) begin
                    load_strobe = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_CALC;
                end else if (!load_div_n) begin
                    div_load = 1'b1;
                end
            end
            S_CALC: begin
                step_en = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done_strobe = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (run_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - unsigned restoring divider, one quotient bit per clock
// Optional seven-segment outputs are built when DIVIDER_HEX_EN is defined.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic     Clk,
    input  logic     Reset,
    divider_if.slave bus
);

    logic             load_strobe, div_load, step_en, done_strobe;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    divider_control #(.WIDTH(WIDTH)) u_ctrl (
        .Clk         (Clk),
        .Reset       (Reset),
        .run_n       (bus.Run),
        .load_div_n  (bus.LoadDivisor),
        .load_strobe (load_strobe),
        .div_load    (div_load),
        .step_en     (step_en),
        .done_strobe (done_strobe)
    );

    // Since R < D is invariant, the shifted partial remainder is below 2D and
    // a WIDTH+1 bit difference has a trustworthy sign bit.
    assign shifted = {r_q, q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_q};

    always_comb begin
        d_d    = d_q;
        r_d    = r_q;
        q_d    = q_q;
        done_d = done_q;
        dbz_d  = dbz_q;
        if (load_strobe) begin
            q_d    = bus.SW;
            r_d    = '0;
            done_d = 1'b0;
            dbz_d  = (d_q == '0);
        end else if (step_en) begin
            if (!trial[WIDTH]) begin
                r_d = trial[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                r_d = shifted[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], 1'b0};
            end
        end else if (done_strobe) begin
            done_d = 1'b1;
        end else if (div_load) begin
            d_d = bus.SW;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            d_q    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            d_q    <= d_d;
            r_q    <= r_d;
            q_q    <= q_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    assign bus.Quotient  = q_q;
    assign bus.Remainder = r_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;

`ifdef DIVIDER_HEX_EN
    assign bus.QhexU = hex_to_seg(q_q[7:4]);
    assign bus.QhexL = hex_to_seg(q_q[3:0]);
    assign bus.RhexU = hex_to_seg(r_q[7:4]);
    assign bus.RhexL = hex_to_seg(r_q[3:0]);
`endif

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed and random checks of divider against an arithmetic reference
module tb_divider;
    import divider_pkg::*;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset;
    int   vectors = 0;
    int   errs    = 0;
    logic [7:0] m_d;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    divider_if #(.WIDTH(W)) bus ();

    divider #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] d);
        if (d == 8'd0) return {8'hFF, a};
        return {a / d, a % d};
    endfunction

    task automatic check_result(input string tag, input logic [7:0] a);
        logic [15:0] e;
        e = model(a, m_d);
        chk({tag, "_quot"}, bus.Quotient, e[15:8]);
        chk({tag, "_rem"},  bus.Remainder, e[7:0]);
        chk({tag, "_done"}, bus.Done, 1);
        chk({tag, "_dbz"},  bus.DivByZero, (m_d == 8'd0));
        if (m_d != 8'd0) chk({tag, "_rem_lt_d"}, (bus.Remainder < m_d), 1);
    endtask

    task automatic load_div(input logic [7:0] d);
        @(negedge Clk);
        bus.LoadDivisor = 1'b0;
        bus.SW          = d;
        @(negedge Clk);
        bus.LoadDivisor = 1'b1;
        m_d = d;
    endtask

    task automatic do_run(input string tag, input logic [7:0] a, input logic both_low);
        @(negedge Clk);
        bus.Run = 1'b0;
        bus.SW  = a;
        if (both_low) bus.LoadDivisor = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        bus.Run         = 1'b1;
        bus.LoadDivisor = 1'b1;
        bus.SW          = 8'($urandom);
        repeat (8) @(posedge Clk);
        #1;
        chk({tag, "_done_early"}, bus.Done, 0);
        @(posedge Clk);
        #1;
        check_result(tag, a);
        @(posedge Clk);
        #1;
        chk({tag, "_hold_idle"}, bus.Done, 1);
    endtask

    initial begin
        logic [7:0] rd, ra;
        Reset           = 1'b1;
        bus.LoadDivisor = 1'b1;
        bus.Run         = 1'b1;
        bus.SW          = 8'h00;
        m_d             = 8'd0;
        #2;
        chk("rst_quot", bus.Quotient, 0);
        chk("rst_rem", bus.Remainder, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_dbz", bus.DivByZero, 0);
        chk("rst_state", dut.u_ctrl.state_q, IDLE);
        @(negedge Clk);
        Reset = 1'b0;

        load_div(8'd7);
        do_run("d7_100", 8'd100, 1'b0);
`ifdef DIVIDER_HEX_EN
        chk("hex_qu", bus.QhexU, seg_tab[0]);
        chk("hex_ql", bus.QhexL, seg_tab[14]);
        chk("hex_ru", bus.RhexU, seg_tab[0]);
        chk("hex_rl", bus.RhexL, seg_tab[2]);
`else
        chk("seg_tab_sanity", {25'd0, seg_tab[bus.Quotient[3:0]]}, 32'h06);
`endif

        load_div(8'd1);
        do_run("d1_255", 8'd255, 1'b0);
        load_div(8'd10);
        do_run("d10_5", 8'd5, 1'b0);
        load_div(8'd0);
        do_run("d0_5a", 8'h5A, 1'b0);

        load_div(8'd7);
        do_run("both_low", 8'd50, 1'b1);

        // Reset during the fourth CALC cycle, observed before any further edge.
        load_div(8'd7);
        @(negedge Clk);
        bus.Run = 1'b0;
        bus.SW  = 8'd200;
        @(posedge Clk);
        @(negedge Clk);
        bus.Run = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        chk("mid_rst_quot", bus.Quotient, 0);
        chk("mid_rst_rem", bus.Remainder, 0);
        chk("mid_rst_done", bus.Done, 0);
        chk("mid_rst_dbz", bus.DivByZero, 0);
        chk("mid_rst_state", dut.u_ctrl.state_q, IDLE);
        chk("mid_rst_cnt", dut.u_ctrl.cnt_q, 0);
        @(negedge Clk);
        Reset = 1'b0;
        m_d   = 8'd0;
        do_run("post_rst", 8'h33, 1'b0);

        // Run held low for 20 cycles with a divisor load attempt mid-division.
        load_div(8'd9);
        @(negedge Clk);
        bus.Run = 1'b0;
        bus.SW  = 8'd100;
        @(posedge Clk);
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk);
            #1;
            if (i == 2) begin
                bus.LoadDivisor = 1'b0;
                bus.SW          = 8'd3;
            end
            if (i == 4) bus.LoadDivisor = 1'b1;
            if (i == 8) chk("held_done_early", bus.Done, 0);
            if (i == 9 || i == 20) check_result("held", 8'd100);
        end
        bus.Run = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_result("held_idle", 8'd100);
        do_run("after_held", 8'd45, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            ra = 8'($urandom);
            load_div(rd);
            do_run("rand", ra, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
